rename_log: RTL and testbench
=============================

// Module: rename_log
// PURPOSE
//  Rename history log and RAT-restore sequencer for one PRF (prf_type).
//  - Records every rename (gpr, new pdst, old pdst) in a circular log.
//  - Retire path: frees the old pdst through the PRF reclaim port.
//  - Flush path: walks younger entries youngest-first.
//    - Drives rat_restore_pkt_rbx to roll MAP back.
//    - Reclaims each discarded pdst.
//  - Sits between rename and the PRF.
// PARAMETERS
//  LOG_DEPTH  32  log entries; power of 2, >=4
//  ID_W       $clog2(LOG_DEPTH)+1  log id width; MSB is the wrap bit
// PORTS
//  clk                 in   1      clock
//  reset_n             in   1      async active-low reset
//  prf_type            in   t_prf_type  PRF this log serves
//  rec_en_rn1          in   1      record rename (alloc_pdst one cycle late)
//  rec_gpr_rn1         in   t_gpr_id    renamed arch reg
//  rec_pdst_rn1        in   t_prf_id    new pdst
//  rec_pdst_old_rn1    in   t_prf_id    previous mapping
//  rec_id_rn1          out  ID_W   id given to the recorded entry (=tail)
//  log_ready_rn0       out  1      rename may allocate this cycle
//  retire_rb0          in   1      retire oldest entry
//  retire_id_rb0       in   ID_W   must equal head
//  retire_ready_rb0    out  1      retire accepted
//  flush_rbx           in   1      discard all entries younger than flush_id_rbx
//  flush_id_rbx        in   ID_W   last surviving entry
//  reclaim_prf_rb1     out  1      free reclaim_prf_id_rb1
//  reclaim_prf_id_rb1  out  t_prf_id
//  rat_restore_pkt_rbx out  t_rat_restore_pkt  {valid,gpr,prfid}
//  walk_busy           out  1      restore walk in progress
// BEHAVIOUR
//  - Reset (async on reset_n low) clears state:
//    - head=tail=0; state=IDLE.
//    - Outputs: reclaim_prf_rb1=0, rat_restore_pkt_rbx.valid=0, walk_busy=0.
//    - log_ready_rn0=1, retire_ready_rb0=1.
//    - Log storage is not reset.
//  - Occupancy = tail-head over ID_W bits.
//    - Full when the MSBs differ and the low bits are equal.
//    - All pointers wrap modulo 2*LOG_DEPTH.
//  - log_ready_rn0 = IDLE & ~flush_rbx & occupancy + rec_en_rn1 < LOG_DEPTH.
//    - This covers the in-flight rn1 record.
//  - Record: rec_en_rn1 & IDLE & ~flush_rbx -> write log[tail], tail++.
//    - rec_en_rn1 with flush_rbx is dropped (that instruction is flushed).
//    - rec_en_rn1 in WALK is dropped and flagged by an assertion.
//  - Retire (retire_ready_rb0 = IDLE):
//    - Accepted retire pops head.
//    - Next cycle: reclaim_prf_rb1=1, reclaim_prf_id_rb1 = log[head].pdst_old.
//    - Assertions: retire_id_rb0==head; log not empty.
//  - State machine IDLE/WALK:
//    - IDLE, flush_rbx: target = flush_id_rbx+1.
//      - target==tail: stay IDLE; no output.
//      - Otherwise: -> WALK; tail is unchanged in the flush cycle.
//    - WALK, each cycle: e = log[tail-1]; tail--.
//      - Next cycle: rat_restore_pkt_rbx = {1, e.gpr, e.pdst_old}.
//      - Same next cycle: reclaim_prf_rb1=1, reclaim_prf_id_rb1 = e.pdst.
//      - When tail-1 == target: -> IDLE.
//    - Flush in WALK with target older than the current target (age relative to head):
//      retarget and keep walking.
//    - Flush in WALK that is younger or equal: ignored.
//  - walk_busy = (state==WALK) | rat_restore_pkt_rbx.valid.
//    - Rename stays stalled until the last restore packet has been presented.
//  - Reclaim port has one user per cycle by construction:
//    - Retire happens only in IDLE.
//    - Walk output lags by one cycle.
//    - Retire in a flush cycle is legal: it reclaims at t+1; the walk's first reclaim is at t+2.
//  - Walk length = number of discarded entries; at most LOG_DEPTH-1 cycles plus 1 output cycle.
//  - Reset mid-walk: everything returns to IDLE immediately; no further packets.
// STRUCTURE
//  - rename_defs package gains:
//    - t_rename_log_id (ID_W bits);
//    - t_rename_log_entry {t_gpr_id gpr; t_prf_id pdst; t_prf_id pdst_old};
//    - t_rename_log_state enum {RL_IDLE, RL_WALK}.
//  - Age compare: (id - head) over ID_W bits, in a gen_funcs function.
//  - One sub-module: rename_log_ram (LOG_DEPTH x entry, 1W/2R, comb read, no reset).
// TESTING
//  1 Reset, record 3 renames (gpr 5,6,7; pdst 40,41,42; old 5,6,7):
//    -> rec_id 0,1,2; tail=3.
//  2 Retire id 0 -> next cycle reclaim_prf_rb1=1, reclaim id idx 5; head=1.
//  3 Ten entries, flush_id=3 -> walk_busy.
//    -> Six restore packets, youngest first (ids 9..4), one per cycle, each reclaiming its pdst.
//    -> tail=4; log_ready_rn0 rises the cycle after the last packet.
//  4 Flush_id == tail-1 -> no walk; IDLE next cycle; no packets.
//  5 Fill to LOG_DEPTH -> log_ready_rn0=0.
//    -> Retire one: ready returns.
//    -> Pointer wrap: ids 31->32 (wrap bit set); walk across the wrap restores correctly.
//  6 Flush at id 8 during a walk, then flush at id 2 two cycles later -> walk ends at id 3.
//    -> Assert reset_n low mid-walk: all outputs 0 at once.

Source files
------------

// File: rtl/rename_log_pkg.sv
// rename_log_pkg: shared types, sizes and age helper for the rename history log
package rename_log_pkg;
  localparam int RL_LOG_DEPTH = 32;
  localparam int RL_ID_W = $clog2(RL_LOG_DEPTH) + 1;
  localparam int RL_IDX_W = RL_ID_W - 1;
  localparam int GPR_W = 5;
  localparam int PRF_W = 7;
  typedef enum logic {PRF_INT, PRF_FP} t_prf_type;
  typedef logic [GPR_W-1:0] t_gpr_id;
  typedef logic [PRF_W-1:0] t_prf_id;
  typedef logic [RL_ID_W-1:0] t_rename_log_id;
  typedef struct packed {
    logic    valid;
    t_gpr_id gpr;
    t_prf_id prfid;
  } t_rat_restore_pkt;
  typedef struct packed {
    t_gpr_id gpr;
    t_prf_id pdst;
    t_prf_id pdst_old;
  } t_rename_log_entry;
  typedef enum logic {RL_IDLE, RL_WALK} t_rename_log_state;
  // Distance from head; smaller means older. Wraps naturally over the id width.
  function automatic t_rename_log_id rl_age(input t_rename_log_id id, input t_rename_log_id head);
    return id - head;
  endfunction
endpackage

// File: rtl/rename_log_ram.sv
// rename_log_ram: log storage, one write port, walk read port and retire read port
module rename_log_ram
  import rename_log_pkg::*;
#(
  parameter int DEPTH = RL_LOG_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  t_rename_log_entry wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output t_rename_log_entry rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output t_prf_id           rdata_b_o
);
  t_rename_log_entry mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_a_o = mem_q[raddr_a_i];
  // Retire only ever needs the previous mapping to free it.
  assign rdata_b_o = mem_q[raddr_b_i].pdst_old;
endmodule

// File: rtl/rename_log.sv
// rename_log: rename history log with retire reclaim and youngest-first RAT restore walk
module rename_log
  import rename_log_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  t_prf_type        prf_type,
  input  logic             rec_en_rn1,
  input  t_gpr_id          rec_gpr_rn1,
  input  t_prf_id          rec_pdst_rn1,
  input  t_prf_id          rec_pdst_old_rn1,
  output t_rename_log_id   rec_id_rn1,
  output logic             log_ready_rn0,
  input  logic             retire_rb0,
  input  t_rename_log_id   retire_id_rb0,
  output logic             retire_ready_rb0,
  input  logic             flush_rbx,
  input  t_rename_log_id   flush_id_rbx,
  output logic             reclaim_prf_rb1,
  output t_prf_id          reclaim_prf_id_rb1,
  output t_rat_restore_pkt rat_restore_pkt_rbx,
  output logic             walk_busy
);
  localparam t_rename_log_id ONE = t_rename_log_id'(1);
  localparam t_rename_log_id DEPTH_ID = t_rename_log_id'(RL_LOG_DEPTH);
  t_rename_log_state state_q, state_d;
  t_rename_log_id head_q, head_d, tail_q, tail_d, target_q, target_d;
  logic reclaim_q, reclaim_d;
  t_prf_id reclaim_id_q, reclaim_id_d;
  t_rat_restore_pkt pkt_q, pkt_d;
  t_rename_log_id occ, tail_m1, flush_tgt, walk_tgt;
  logic idle, rec_we, retire_ok, flush_walk, retarget;
  t_rename_log_entry walk_e;
  t_prf_id retire_old;
  assign idle = state_q == RL_IDLE;
  assign occ = tail_q - head_q;
  assign tail_m1 = tail_q - ONE;
  assign flush_tgt = flush_id_rbx + ONE;
  assign rec_we = rec_en_rn1 & idle & ~flush_rbx;
  assign retire_ok = retire_rb0 & idle;
  // A flush target at or beyond tail discards nothing and starts no walk.
  assign flush_walk = flush_rbx & (rl_age(flush_tgt, head_q) < occ);
  assign retarget = flush_rbx & (rl_age(flush_tgt, head_q) < rl_age(target_q, head_q));
  assign walk_tgt = retarget ? flush_tgt : target_q;
  rename_log_ram #(.DEPTH(RL_LOG_DEPTH), .AW(RL_IDX_W)) u_ram (
    .clk       (clk),
    .we_i      (rec_we),
    .waddr_i   (tail_q[RL_IDX_W-1:0]),
    .wdata_i   ('{gpr: rec_gpr_rn1, pdst: rec_pdst_rn1, pdst_old: rec_pdst_old_rn1}),
    .raddr_a_i (tail_m1[RL_IDX_W-1:0]),
    .rdata_a_o (walk_e),
    .raddr_b_i (head_q[RL_IDX_W-1:0]),
    .rdata_b_o (retire_old)
  );
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    tail_d = rec_we ? tail_q + ONE : tail_q;
    head_d = retire_ok ? head_q + ONE : head_q;
    reclaim_d = retire_ok;
    reclaim_id_d = retire_ok ? retire_old : '0;
    pkt_d = '0;
    if (idle) begin
      if (flush_walk) begin
        state_d = RL_WALK;
        target_d = flush_tgt;
      end
    end else begin
      tail_d = tail_m1;
      target_d = walk_tgt;
      reclaim_d = 1'b1;
      reclaim_id_d = walk_e.pdst;
      pkt_d = '{valid: 1'b1, gpr: walk_e.gpr, prfid: walk_e.pdst_old};
      if (tail_m1 == walk_tgt) state_d = RL_IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RL_IDLE;
      head_q <= '0;
      tail_q <= '0;
      target_q <= '0;
      reclaim_q <= 1'b0;
      reclaim_id_q <= '0;
      pkt_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      target_q <= target_d;
      reclaim_q <= reclaim_d;
      reclaim_id_q <= reclaim_id_d;
      pkt_q <= pkt_d;
    end
  end
  assign rec_id_rn1 = tail_q;
  assign retire_ready_rb0 = idle;
  assign reclaim_prf_rb1 = reclaim_q;
  assign reclaim_prf_id_rb1 = reclaim_id_q;
  assign rat_restore_pkt_rbx = pkt_q;
  assign walk_busy = ~idle | pkt_q.valid;
  // Rename stays stalled until the last restore packet has gone out.
  assign log_ready_rn0 = ~walk_busy & ~flush_rbx & (occ < (rec_en_rn1 ? DEPTH_ID - ONE : DEPTH_ID));
  a_rec_in_walk: assert property (@(posedge clk) disable iff (!reset_n) !(rec_en_rn1 && !idle));
  a_retire_head: assert property (@(posedge clk) disable iff (!reset_n)
    retire_ok |-> (retire_id_rb0 == head_q) && (occ != '0));
  a_prf_type_static: assert property (@(posedge clk) disable iff (!reset_n) $stable(prf_type));
endmodule

// File: tb/tb_rename_log.sv
// tb_rename_log: table-driven cycle vectors plus directed wrap, retarget and reset-mid-walk sequences
module tb_rename_log;
  import rename_log_pkg::*;
  typedef struct {
    int rec, gpr, pdst, old, ret, rid, fl, fid;
    int e_id, e_rdy, e_rrdy, e_rcl, e_rcl_id, e_pv, e_pgpr, e_pprf, e_busy;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  t_prf_type prf_type = PRF_INT;
  logic rec_en_rn1 = 1'b0;
  t_gpr_id rec_gpr_rn1 = '0;
  t_prf_id rec_pdst_rn1 = '0;
  t_prf_id rec_pdst_old_rn1 = '0;
  t_rename_log_id rec_id_rn1;
  logic log_ready_rn0;
  logic retire_rb0 = 1'b0;
  t_rename_log_id retire_id_rb0 = '0;
  logic retire_ready_rb0;
  logic flush_rbx = 1'b0;
  t_rename_log_id flush_id_rbx = '0;
  logic reclaim_prf_rb1;
  t_prf_id reclaim_prf_id_rb1;
  t_rat_restore_pkt rat_restore_pkt_rbx;
  logic walk_busy;
  int checks = 0;
  int errors = 0;
  int m_gpr [64];
  int m_pdst [64];
  int m_old [64];
  int head_m, tail_m;
  vec_t vq [$];
  always #5 clk = ~clk;
  rename_log dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .prf_type            (prf_type),
    .rec_en_rn1          (rec_en_rn1),
    .rec_gpr_rn1         (rec_gpr_rn1),
    .rec_pdst_rn1        (rec_pdst_rn1),
    .rec_pdst_old_rn1    (rec_pdst_old_rn1),
    .rec_id_rn1          (rec_id_rn1),
    .log_ready_rn0       (log_ready_rn0),
    .retire_rb0          (retire_rb0),
    .retire_id_rb0       (retire_id_rb0),
    .retire_ready_rb0    (retire_ready_rb0),
    .flush_rbx           (flush_rbx),
    .flush_id_rbx        (flush_id_rbx),
    .reclaim_prf_rb1     (reclaim_prf_rb1),
    .reclaim_prf_id_rb1  (reclaim_prf_id_rb1),
    .rat_restore_pkt_rbx (rat_restore_pkt_rbx),
    .walk_busy           (walk_busy)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic record_one(input int id);
    m_gpr[id % 64] = (id * 3) % 32;
    m_pdst[id % 64] = (id + 40) % 128;
    m_old[id % 64] = (id * 5 + 1) % 128;
    rec_en_rn1 = 1'b1;
    rec_gpr_rn1 = t_gpr_id'(m_gpr[id % 64]);
    rec_pdst_rn1 = t_prf_id'(m_pdst[id % 64]);
    rec_pdst_old_rn1 = t_prf_id'(m_old[id % 64]);
    #1;
    chk($sformatf("rec%0d rec_id", id), int'(rec_id_rn1), tail_m % 64);
    chk($sformatf("rec%0d log_ready", id), int'(log_ready_rn0), (tail_m - head_m + 1 < 32) ? 1 : 0);
    step();
    rec_en_rn1 = 1'b0;
    tail_m++;
  endtask
  // Walk from tail down to last; with retgt, extra flushes (8, 15, 2) follow the first one.
  task automatic run_walk(input int fid, input int last, input bit retgt);
    int exp_id;
    int n;
    bit done;
    exp_id = tail_m - 1;
    n = 0;
    done = 1'b0;
    flush_rbx = 1'b1;
    flush_id_rbx = t_rename_log_id'(fid);
    for (int k = 0; k < 64 && !done; k++) begin
      step();
      flush_rbx = retgt && k < 3;
      flush_id_rbx = t_rename_log_id'(k == 0 ? 8 : k == 1 ? 15 : 2);
      if (k == 0) chk("walk_busy_start", int'(walk_busy), 1);
      if (rat_restore_pkt_rbx.valid) begin
        chk($sformatf("walk pkt_gpr id%0d", exp_id), int'(rat_restore_pkt_rbx.gpr), m_gpr[exp_id % 64]);
        chk($sformatf("walk pkt_prf id%0d", exp_id), int'(rat_restore_pkt_rbx.prfid), m_old[exp_id % 64]);
        chk($sformatf("walk reclaim id%0d", exp_id), int'(reclaim_prf_rb1), 1);
        chk($sformatf("walk reclaim_id id%0d", exp_id), int'(reclaim_prf_id_rb1), m_pdst[exp_id % 64]);
        exp_id--;
        n++;
      end
      done = !walk_busy;
    end
    flush_rbx = 1'b0;
    #1;
    chk("walk_finished", int'(done), 1);
    chk("walk_len", n, tail_m - last);
    chk("walk_tail", int'(rec_id_rn1), last % 64);
    tail_m = last;
  endtask
  initial begin
    vq.push_back(vec_t'{1,5,40,5, 0,0,0,0, 0,1,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{1,6,41,6, 0,0,0,0, 1,1,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{1,7,42,7, 0,0,0,0, 2,1,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{0,0,0,0, 1,0,0,0, 3,1,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{0,0,0,0, 0,0,0,0, 3,1,1, 1,5, 0,0,0, 0});
    for (int i = 3; i <= 9; i++) vq.push_back(vec_t'{1,i+5,40+i,80+i, 0,0,0,0, i,1,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{0,0,0,0, 0,0,1,3, 10,0,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{0,0,0,0, 0,0,0,0, 10,0,0, 0,0, 0,0,0, 1});
    for (int j = 9; j >= 4; j--) vq.push_back(vec_t'{0,0,0,0, 0,0,0,0, j,0,(j == 4) ? 1 : 0, 1,40+j, 1,j+5,80+j, 1});
    vq.push_back(vec_t'{0,0,0,0, 0,0,0,0, 4,1,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{0,0,0,0, 0,0,1,3, 4,0,1, 0,0, 0,0,0, 0});
    vq.push_back(vec_t'{0,0,0,0, 0,0,0,0, 4,1,1, 0,0, 0,0,0, 0});
    #3;
    chk("reset reclaim", int'(reclaim_prf_rb1), 0);
    chk("reset pkt_valid", int'(rat_restore_pkt_rbx.valid), 0);
    chk("reset walk_busy", int'(walk_busy), 0);
    chk("reset log_ready", int'(log_ready_rn0), 1);
    chk("reset retire_ready", int'(retire_ready_rb0), 1);
    chk("reset rec_id", int'(rec_id_rn1), 0);
    step();
    step();
    reset_n = 1'b1;
    foreach (vq[i]) begin
      rec_en_rn1 = vq[i].rec != 0;
      rec_gpr_rn1 = t_gpr_id'(vq[i].gpr);
      rec_pdst_rn1 = t_prf_id'(vq[i].pdst);
      rec_pdst_old_rn1 = t_prf_id'(vq[i].old);
      retire_rb0 = vq[i].ret != 0;
      retire_id_rb0 = t_rename_log_id'(vq[i].rid);
      flush_rbx = vq[i].fl != 0;
      flush_id_rbx = t_rename_log_id'(vq[i].fid);
      #1;
      chk($sformatf("row%0d rec_id", i), int'(rec_id_rn1), vq[i].e_id);
      chk($sformatf("row%0d log_ready", i), int'(log_ready_rn0), vq[i].e_rdy);
      chk($sformatf("row%0d retire_ready", i), int'(retire_ready_rb0), vq[i].e_rrdy);
      chk($sformatf("row%0d reclaim", i), int'(reclaim_prf_rb1), vq[i].e_rcl);
      chk($sformatf("row%0d reclaim_id", i), int'(reclaim_prf_id_rb1), vq[i].e_rcl_id);
      chk($sformatf("row%0d pkt_valid", i), int'(rat_restore_pkt_rbx.valid), vq[i].e_pv);
      chk($sformatf("row%0d pkt_gpr", i), int'(rat_restore_pkt_rbx.gpr), vq[i].e_pgpr);
      chk($sformatf("row%0d pkt_prf", i), int'(rat_restore_pkt_rbx.prfid), vq[i].e_pprf);
      chk($sformatf("row%0d walk_busy", i), int'(walk_busy), vq[i].e_busy);
      step();
    end
    rec_en_rn1 = 1'b0;
    retire_rb0 = 1'b0;
    flush_rbx = 1'b0;
    m_gpr[1] = 6; m_pdst[1] = 41; m_old[1] = 6;
    m_gpr[2] = 7; m_pdst[2] = 42; m_old[2] = 7;
    m_gpr[3] = 8; m_pdst[3] = 43; m_old[3] = 83;
    head_m = 1;
    tail_m = 4;
    for (int id = 4; id <= 32; id++) record_one(id);
    #1;
    chk("full log_ready", int'(log_ready_rn0), 0);
    chk("full rec_id", int'(rec_id_rn1), 33);
    retire_rb0 = 1'b1;
    retire_id_rb0 = t_rename_log_id'(1);
    #1;
    chk("full retire_ready", int'(retire_ready_rb0), 1);
    step();
    retire_rb0 = 1'b0;
    #1;
    chk("full retire reclaim", int'(reclaim_prf_rb1), 1);
    chk("full retire reclaim_id", int'(reclaim_prf_id_rb1), 6);
    chk("after retire log_ready", int'(log_ready_rn0), 1);
    head_m = 2;
    run_walk(29, 30, 1'b0);
    run_walk(20, 3, 1'b1);
    for (int id = 3; id < 8; id++) record_one(id);
    flush_rbx = 1'b1;
    flush_id_rbx = t_rename_log_id'(2);
    step();
    flush_rbx = 1'b0;
    step();
    step();
    chk("pre_reset pkt_valid", int'(rat_restore_pkt_rbx.valid), 1);
    chk("pre_reset pkt_gpr", int'(rat_restore_pkt_rbx.gpr), m_gpr[6]);
    reset_n = 1'b0;
    #1;
    chk("midwalk reset reclaim", int'(reclaim_prf_rb1), 0);
    chk("midwalk reset pkt_valid", int'(rat_restore_pkt_rbx.valid), 0);
    chk("midwalk reset walk_busy", int'(walk_busy), 0);
    chk("midwalk reset log_ready", int'(log_ready_rn0), 1);
    chk("midwalk reset retire_ready", int'(retire_ready_rb0), 1);
    chk("midwalk reset rec_id", int'(rec_id_rn1), 0);
    step();
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_reset%0d pkt_valid", k), int'(rat_restore_pkt_rbx.valid), 0);
      chk($sformatf("post_reset%0d walk_busy", k), int'(walk_busy), 0);
      chk($sformatf("post_reset%0d reclaim", k), int'(reclaim_prf_rb1), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
